// File: rtl/ic_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ic_ram_arb
// Purpose  : Two-to-one (IMEM/DMEM) round-robin arbiter in front of a
//            synchronous single-port SRAM. One transaction in flight at a
//            time; the response is registered and held until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module ic_ram_arb #(
    parameter int AW = 14
) (
    input  logic          g_clk,
    input  logic          g_resetn,

    input  logic          imem_req,
    input  logic          imem_wen,
    input  logic [3:0]    imem_strb,
    input  logic [31:0]   imem_wdata,
    input  logic [31:0]   imem_addr,
    output logic          imem_gnt,
    output logic          imem_recv,
    input  logic          imem_ack,
    output logic          imem_error,
    output logic [31:0]   imem_rdata,

    input  logic          dmem_req,
    input  logic          dmem_wen,
    input  logic [3:0]    dmem_strb,
    input  logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_addr,
    output logic          dmem_gnt,
    output logic          dmem_recv,
    input  logic          dmem_ack,
    output logic          dmem_error,
    output logic [31:0]   dmem_rdata,

    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_wstrb,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    // Port identifiers used for both the round-robin history and the owner.
    localparam logic c_IMEM = 1'b0;
    localparam logic c_DMEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;      // port that won the most recent grant
    logic        r_owner;     // port owning the in-flight transaction
    logic        r_err;       // in-flight request was misaligned
    logic        r_rd;        // in-flight request is an aligned read
    logic [31:0] r_rsp_data;

    logic        w_owner_ack;
    logic        w_arb_en;
    logic        w_imem_win;
    logic        w_dmem_win;
    logic        w_grant;
    logic        w_sel_wen;
    logic [3:0]  w_sel_strb;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_sel_addr;
    logic        w_aligned;
    logic        w_issue;
    logic        w_rsp;
    logic        w_unused;

    // Arbitration is open when idle, or when the owner consumes its response.
    // Gating with the reset keeps every grant low while reset is held.
    assign w_owner_ack = (r_state == ST_RSP) &&
                         ((r_owner == c_DMEM) ? dmem_ack : imem_ack);
    assign w_arb_en    = g_resetn && ((r_state == ST_IDLE) || w_owner_ack);

    // A tie goes to whichever port did not win last time.
    assign w_imem_win  = w_arb_en && imem_req && (!dmem_req || (r_last == c_DMEM));
    assign w_dmem_win  = w_arb_en && dmem_req && (!imem_req || (r_last == c_IMEM));
    assign w_grant     = w_imem_win || w_dmem_win;

    assign w_sel_wen   = w_dmem_win ? dmem_wen   : imem_wen;
    assign w_sel_strb  = w_dmem_win ? dmem_strb  : imem_strb;
    assign w_sel_wdata = w_dmem_win ? dmem_wdata : imem_wdata;
    assign w_sel_addr  = w_dmem_win ? dmem_addr  : imem_addr;

    // Misaligned requests are granted but never reach the SRAM.
    assign w_aligned   = (w_sel_addr[1:0] == 2'b00);
    assign w_issue     = w_grant && w_aligned;

    assign imem_gnt    = w_imem_win;
    assign dmem_gnt    = w_dmem_win;

    assign sram_cen    = w_issue;
    assign sram_wen    = w_issue && w_sel_wen;
    assign sram_wstrb  = (w_issue && w_sel_wen) ? w_sel_strb : 4'b0000;
    assign sram_addr   = w_issue ? w_sel_addr[AW+1:2] : '0;
    assign sram_wdata  = w_issue ? w_sel_wdata : 32'h0;

    // Response is steered to the owner only; the other port sees zeros.
    assign w_rsp       = (r_state == ST_RSP);
    assign imem_recv   = w_rsp && (r_owner == c_IMEM);
    assign dmem_recv   = w_rsp && (r_owner == c_DMEM);
    assign imem_error  = imem_recv && r_err;
    assign dmem_error  = dmem_recv && r_err;
    assign imem_rdata  = imem_recv ? r_rsp_data : 32'h0;
    assign dmem_rdata  = dmem_recv ? r_rsp_data : 32'h0;

    // Upper byte-address bits lie outside the SRAM and are intentionally dropped.
    assign w_unused    = &{1'b0, imem_addr[31:AW+2], dmem_addr[31:AW+2]};

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a grant always leads to CAPT, CAPT always to RSP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                if (w_owner_ack) begin
                    w_state_nxt = w_grant ? ST_CAPT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction bookkeeping on grant and response-data capture in CAPT.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_last     <= c_IMEM;
            r_owner    <= c_IMEM;
            r_err      <= 1'b0;
            r_rd       <= 1'b0;
            r_rsp_data <= 32'h0;
        end else begin
            if (w_grant) begin
                r_last  <= w_dmem_win;
                r_owner <= w_dmem_win;
                r_err   <= !w_aligned;
                r_rd    <= w_aligned && !w_sel_wen;
            end
            if (r_state == ST_CAPT) begin
                r_rsp_data <= r_rd ? sram_rdata : 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ic_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic_ram_arb
// Purpose  : Self-checking bench for ic_ram_arb with an SRAM model and a
//            word-level reference memory plus round-robin history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ic_ram_arb;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          g_clk = 1'b0;
    logic          g_resetn = 1'b0;
    logic          imem_req = 0, imem_wen = 0, imem_ack = 0;
    logic [3:0]    imem_strb = 0;
    logic [31:0]   imem_wdata = 0, imem_addr = 0;
    logic          imem_gnt, imem_recv, imem_error;
    logic [31:0]   imem_rdata;
    logic          dmem_req = 0, dmem_wen = 0, dmem_ack = 0;
    logic [3:0]    dmem_strb = 0;
    logic [31:0]   dmem_wdata = 0, dmem_addr = 0;
    logic          dmem_gnt, dmem_recv, dmem_error;
    logic [31:0]   dmem_rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wstrb;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 0;

    logic [31:0]   tb_mem  [DEPTH];   // physical SRAM contents
    logic [31:0]   ref_mem [DEPTH];   // expected contents
    bit            exp_last;          // 0 = IMEM won last, 1 = DMEM
    int            n_cmp = 0;
    int            n_err = 0;

    ic_ram_arb #(.AW(AW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 g_clk = ~g_clk;

    // Synchronous single-port SRAM with byte write enables.
    always @(posedge g_clk) begin
        if (sram_cen) begin
            if (sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb[b]) tb_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            sram_rdata <= tb_mem[sram_addr];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic set_req(input bit port, input bit req, input bit wen, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] addr);
        if (!port) begin
            imem_req = req; imem_wen = wen; imem_strb = strb; imem_wdata = wdata; imem_addr = addr;
        end else begin
            dmem_req = req; dmem_wen = wen; dmem_strb = strb; dmem_wdata = wdata; dmem_addr = addr;
        end
    endtask

    // Drives one transaction on an otherwise idle arbiter and reports what it saw.
    task automatic run_txn(input bit port, input bit wen, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] addr,
                           output bit g, output bit cen, output logic [AW-1:0] sa,
                           output int lat, output logic [31:0] rd, output bit er);
        @(negedge g_clk);
        set_req(port, 1'b1, wen, strb, wdata, addr);
        #1;
        g = port ? dmem_gnt : imem_gnt;
        cen = sram_cen;
        sa = sram_addr;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge g_clk);
            if (k == 1) set_req(port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #1;
            if (port ? dmem_recv : imem_recv) begin
                lat = k;
                rd = port ? dmem_rdata : imem_rdata;
                er = port ? dmem_error : imem_error;
                break;
            end
        end
        if (lat != 0) begin
            if (port) dmem_ack = 1'b1; else imem_ack = 1'b1;
            @(negedge g_clk);
            imem_ack = 1'b0; dmem_ack = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        exp_last = 1'b0;
    endtask

    task automatic test_reset();
        bit g, cen, er; int lat; logic [AW-1:0] sa; logic [31:0] rd;
        g_resetn = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h4);
        repeat (2) @(negedge g_clk);
        #1;
        n_cmp++; if (imem_gnt !== 1'b0) begin n_err++; $display("FAIL reset_imem_gnt: got %b want 0", imem_gnt); end
        n_cmp++; if (dmem_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dmem_gnt: got %b want 0", dmem_gnt); end
        n_cmp++; if ({imem_recv, dmem_recv} !== 2'b00) begin n_err++; $display("FAIL reset_recv: got %b want 00", {imem_recv, dmem_recv}); end
        n_cmp++; if ({imem_error, dmem_error} !== 2'b00) begin n_err++; $display("FAIL reset_error: got %b want 00", {imem_error, dmem_error}); end
        n_cmp++; if (sram_cen !== 1'b0) begin n_err++; $display("FAIL reset_cen: got %b want 0", sram_cen); end
        @(negedge g_clk);
        g_resetn = 1'b1;
        exp_last = 1'b0;
        #1;
        n_cmp++; if ({imem_gnt, dmem_gnt} !== {exp_last, !exp_last}) begin n_err++; $display("FAIL first_tie: got i/d=%b want %b", {imem_gnt, dmem_gnt}, {exp_last, !exp_last}); end
        @(negedge g_clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge g_clk); #1;
        n_cmp++; if (dmem_recv !== 1'b1 || dmem_rdata !== ref_mem[1]) begin n_err++; $display("FAIL first_tie_rsp: got recv=%b data=%h want 1 %h", dmem_recv, dmem_rdata, ref_mem[1]); end
        dmem_ack = 1'b1;
        @(negedge g_clk);
        dmem_ack = 1'b0;
        exp_last = 1'b1;
        // keep unused outputs of run_txn from complaining
        g = 0; cen = 0; er = 0; lat = 0; sa = '0; rd = '0;
    endtask

    task automatic test_single_read();
        tb_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        @(negedge g_clk);
        set_req(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h40);
        #1;
        n_cmp++; if ({imem_gnt, dmem_gnt} !== 2'b10) begin n_err++; $display("FAIL sr_gnt: got i/d=%b want 10", {imem_gnt, dmem_gnt}); end
        n_cmp++; if (sram_cen !== 1'b1 || sram_addr !== AW'(16)) begin n_err++; $display("FAIL sr_issue: got cen=%b addr=%h want 1 010", sram_cen, sram_addr); end
        @(negedge g_clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (imem_recv !== 1'b0) begin n_err++; $display("FAIL sr_early_recv: got %b want 0", imem_recv); end
        for (int c = 0; c < 3; c++) begin
            @(negedge g_clk); #1;
            n_cmp++; if (imem_recv !== 1'b1 || imem_rdata !== 32'hDEADBEEF || imem_error !== 1'b0) begin n_err++; $display("FAIL sr_hold%0d: got recv=%b data=%h err=%b want 1 deadbeef 0", c, imem_recv, imem_rdata, imem_error); end
            n_cmp++; if (dmem_recv !== 1'b0 || dmem_rdata !== 32'h0) begin n_err++; $display("FAIL sr_other%0d: got recv=%b data=%h want 0 0", c, dmem_recv, dmem_rdata); end
        end
        imem_ack = 1'b1;
        @(negedge g_clk);
        imem_ack = 1'b0;
        #1;
        n_cmp++; if (imem_recv !== 1'b0) begin n_err++; $display("FAIL sr_after_ack: got %b want 0", imem_recv); end
        exp_last = 1'b0;
    endtask

    task automatic test_write_read();
        bit g, cen, er; int lat; logic [AW-1:0] sa; logic [31:0] rd;
        tb_mem[2] = 32'hAABBCCDD; ref_mem[2] = 32'hAABBCCDD;
        run_txn(1, 1'b1, 4'b0101, 32'h11223344, 32'h8, g, cen, sa, lat, rd, er);
        ref_mem[2] = merge(ref_mem[2], 32'h11223344, 4'b0101);
        n_cmp++; if (g !== 1'b1 || cen !== 1'b1 || sa !== AW'(2)) begin n_err++; $display("FAIL wr_issue: got gnt=%b cen=%b addr=%h want 1 1 002", g, cen, sa); end
        n_cmp++; if (lat != 2 || rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL wr_rsp: got lat=%0d data=%h err=%b want 2 0 0", lat, rd, er); end
        run_txn(1, 1'b0, 4'h0, 32'h0, 32'h8, g, cen, sa, lat, rd, er);
        n_cmp++; if (lat != 2 || rd !== ref_mem[2] || rd !== 32'hAA22CC44 || er !== 1'b0) begin n_err++; $display("FAIL rd_back: got lat=%0d data=%h err=%b want 2 aa22cc44 0", lat, rd, er); end
        exp_last = 1'b1;
    endtask

    task automatic test_misaligned();
        bit g, cen, er; int lat; logic [AW-1:0] sa; logic [31:0] rd;
        run_txn(1, 1'b0, 4'h0, 32'h0, 32'h6, g, cen, sa, lat, rd, er);
        n_cmp++; if (g !== 1'b1 || cen !== 1'b0) begin n_err++; $display("FAIL mis_rd_issue: got gnt=%b cen=%b want 1 0", g, cen); end
        n_cmp++; if (lat != 2 || er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL mis_rd_rsp: got lat=%0d err=%b data=%h want 2 1 0", lat, er, rd); end
        run_txn(0, 1'b1, 4'hF, $urandom, 32'h5, g, cen, sa, lat, rd, er);
        n_cmp++; if (cen !== 1'b0 || lat != 2 || er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL mis_wr: got cen=%b lat=%0d err=%b data=%h want 0 2 1 0", cen, lat, er, rd); end
        run_txn(0, 1'b0, 4'h0, 32'h0, 32'h4, g, cen, sa, lat, rd, er);
        n_cmp++; if (rd !== ref_mem[1] || er !== 1'b0) begin n_err++; $display("FAIL mis_untouched: got data=%h err=%b want %h 0", rd, er, ref_mem[1]); end
        exp_last = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [31:0] addr_i, addr_d, pend_addr;
        bit pend_port, have_pend, exp_d;
        pulse_reset();
        addr_i = 32'($urandom_range(0, DEPTH-1)) << 2;
        addr_d = 32'($urandom_range(0, DEPTH-1)) << 2;
        have_pend = 0; pend_port = 0; pend_addr = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge g_clk);
            set_req(0, 1'b1, 1'b0, 4'h0, 32'h0, addr_i);
            set_req(1, 1'b1, 1'b0, 4'h0, 32'h0, addr_d);
            imem_ack = 1'b1; dmem_ack = 1'b1;
            #1;
            if (cyc % 2 == 0) begin
                exp_d = !exp_last;
                n_cmp++; if ({imem_gnt, dmem_gnt} !== {!exp_d, exp_d}) begin n_err++; $display("FAIL rr_gnt c%0d: got i/d=%b want %b", cyc, {imem_gnt, dmem_gnt}, {!exp_d, exp_d}); end
                if (have_pend) begin
                    n_cmp++; if ({imem_recv, dmem_recv} !== {!pend_port, pend_port}) begin n_err++; $display("FAIL rr_recv c%0d: got i/d=%b want %b", cyc, {imem_recv, dmem_recv}, {!pend_port, pend_port}); end
                    n_cmp++; if ((pend_port ? dmem_rdata : imem_rdata) !== ref_mem[pend_addr[AW+1:2]]) begin n_err++; $display("FAIL rr_data c%0d: got %h want %h", cyc, pend_port ? dmem_rdata : imem_rdata, ref_mem[pend_addr[AW+1:2]]); end
                end
                have_pend = 1; pend_port = exp_d; pend_addr = exp_d ? addr_d : addr_i;
                exp_last = exp_d;
                if (exp_d) addr_d = 32'($urandom_range(0, DEPTH-1)) << 2;
                else       addr_i = 32'($urandom_range(0, DEPTH-1)) << 2;
            end else begin
                n_cmp++; if ({imem_gnt, dmem_gnt, imem_recv, dmem_recv} !== 4'b0000) begin n_err++; $display("FAIL rr_capt c%0d: got gnt/recv=%b want 0000", cyc, {imem_gnt, dmem_gnt, imem_recv, dmem_recv}); end
            end
        end
        @(negedge g_clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge g_clk);
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit g, cen, er; int lat; logic [AW-1:0] sa; logic [31:0] rd; logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH-1)) << 2;
        @(negedge g_clk);
        set_req(0, 1'b1, 1'b0, 4'h0, 32'h0, a);
        @(negedge g_clk);
        set_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        g_resetn = 1'b0;
        #1;
        n_cmp++; if ({imem_recv, imem_gnt, sram_cen} !== 3'b000) begin n_err++; $display("FAIL rm_in_reset: got recv/gnt/cen=%b want 000", {imem_recv, imem_gnt, sram_cen}); end
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        exp_last = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge g_clk); #1;
            n_cmp++; if (imem_recv !== 1'b0) begin n_err++; $display("FAIL rm_dropped c%0d: got recv=%b want 0", c, imem_recv); end
        end
        a = 32'($urandom_range(0, DEPTH-1)) << 2;
        run_txn(0, 1'b0, 4'h0, 32'h0, a, g, cen, sa, lat, rd, er);
        n_cmp++; if (g !== 1'b1 || lat != 2 || rd !== ref_mem[a[AW+1:2]] || er !== 1'b0) begin n_err++; $display("FAIL rm_fresh: got gnt=%b lat=%0d data=%h err=%b want 1 2 %h 0", g, lat, rd, er, ref_mem[a[AW+1:2]]); end
        exp_last = 1'b0;
    endtask

    task automatic test_random();
        bit g, cen, er, port, wen, mis; int lat; logic [AW-1:0] sa; logic [31:0] rd, a, wd, exp_rd;
        logic [3:0] strb;
        for (int n = 0; n < 40; n++) begin
            port = 1'($urandom_range(0, 1));
            wen  = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            wd   = $urandom;
            mis  = ($urandom_range(0, 7) == 0);
            a    = (32'($urandom_range(0, DEPTH-1)) << 2) | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
            exp_rd = (!mis && !wen) ? ref_mem[a[AW+1:2]] : 32'h0;
            run_txn(port, wen, strb, wd, a, g, cen, sa, lat, rd, er);
            if (!mis && wen) ref_mem[a[AW+1:2]] = merge(ref_mem[a[AW+1:2]], wd, strb);
            exp_last = port;
            n_cmp++; if (g !== 1'b1 || cen !== !mis || lat != 2) begin n_err++; $display("FAIL rnd_issue%0d: got gnt=%b cen=%b lat=%0d want 1 %b 2", n, g, cen, lat, !mis); end
            n_cmp++; if (rd !== exp_rd || er !== mis) begin n_err++; $display("FAIL rnd_rsp%0d: got data=%h err=%b want %h %b", n, rd, er, exp_rd, mis); end
        end
        for (int n = 0; n < 8; n++) begin
            a = 32'($urandom_range(0, DEPTH-1)) << 2;
            run_txn(1'($urandom_range(0, 1)), 1'b0, 4'h0, 32'h0, a, g, cen, sa, lat, rd, er);
            n_cmp++; if (rd !== ref_mem[a[AW+1:2]]) begin n_err++; $display("FAIL rnd_scan%0d: got %h want %h", n, rd, ref_mem[a[AW+1:2]]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        exp_last = 1'b0;
        test_reset();
        test_single_read();
        test_write_read();
        test_misaligned();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
